// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Entry widths are fixed by WB_XLEN; the arbiter's XLEN parameter must match it.
package wb_arbiter_pkg;

    localparam int unsigned WB_XLEN  = 64;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]         waddr;
        logic [WB_XLEN-1:0] wdata;
        logic [WB_XLEN-1:0] pc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } wb_state_e;

    // A buffered write to x0 never creates a dependency.
    function automatic logic entry_hits(
        input logic [4:0] waddr,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd
    );
        return (waddr != REG_ZERO) && ((waddr == rs1) || (waddr == rs2) || (waddr == rd));
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// DEPTH-entry synchronous FIFO of port-B writeback results.
// Also exposes every slot's rd and a valid mask for the decode hazard compare.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  wb_entry_t              i_push_entry,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DEPTH*5-1:0]     o_waddrs,
    output logic [DEPTH-1:0]       o_valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    wb_entry_t [DEPTH-1:0] r_mem;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic [AW-1:0]         w_off;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_entry;
        end
    end

    assign o_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        o_waddrs = '0;
        o_valid  = '0;
        w_off    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_waddrs[i*5 +: 5] = r_mem[i].waddr;
            w_off              = AW'(i) - r_rptr[AW-1:0];
            o_valid[i]         = ({1'b0, w_off} < o_count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) always wins, buffered
// long-latency results (B) drain into idle slots, with a starvation stall request.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = WB_XLEN,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      a_waddr_i,
    input  logic [XLEN-1:0] a_wdata_i,
    input  logic            a_wen_i,
    input  logic [XLEN-1:0] a_pc_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [4:0]      b_waddr_i,
    input  logic [XLEN-1:0] b_wdata_i,
    input  logic [XLEN-1:0] b_pc_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [4:0]      rd_i,
    output logic            hazard_o,
    output logic            stall_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            reg_wen_o,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic            commit_src_o
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic                  w_a_active;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    wb_entry_t             w_head;
    wb_entry_t             w_push_entry;
    logic [DEPTH*5-1:0]    w_waddrs;
    logic [DEPTH-1:0]      w_valid;
    wb_state_e             r_state;
    wb_state_e             w_state_d;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_d;

    assign w_a_active = a_wen_i && (a_waddr_i != REG_ZERO);
    // Any A slot, even a write to x0, is withheld from B.
    assign w_pop      = !a_wen_i && !w_empty;
    assign b_ready_o  = rst && !w_full;
    assign w_push     = b_valid_i && b_ready_o;

    assign w_push_entry = '{waddr: b_waddr_i, wdata: b_wdata_i, pc: b_pc_i};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_waddrs     (w_waddrs),
        .o_valid      (w_valid)
    );

    always_comb begin
        reg_waddr_o    = REG_ZERO;
        reg_wdata_o    = '0;
        reg_wen_o      = 1'b0;
        commit_valid_o = 1'b0;
        commit_pc_o    = '0;
        commit_src_o   = 1'b0;
        if (a_wen_i) begin
            reg_waddr_o    = a_waddr_i;
            reg_wdata_o    = a_wdata_i;
            reg_wen_o      = w_a_active;
            commit_valid_o = 1'b1;
            commit_pc_o    = a_pc_i;
        end else if (!w_empty) begin
            reg_waddr_o    = w_head.waddr;
            reg_wdata_o    = w_head.wdata;
            reg_wen_o      = (w_head.waddr != REG_ZERO);
            commit_valid_o = 1'b1;
            commit_pc_o    = w_head.pc;
            commit_src_o   = 1'b1;
        end
    end

    // The head being popped this cycle still counts: decode sees it before the write lands.
    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && entry_hits(w_waddrs[i*5 +: 5], rs1_i, rs2_i, rd_i)) begin
                hazard_o = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait;
        unique case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_d = PEND;
                    w_wait_d  = '0;
                end
            end
            PEND: begin
                if (w_pop) begin
                    w_wait_d  = '0;
                    w_state_d = ((w_count > CNT_W'(1)) || w_push) ? PEND : IDLE;
                end else if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
                    w_state_d = FORCE;
                end else begin
                    w_wait_d = r_wait + 1'b1;
                end
            end
            FORCE: begin
                if (w_pop) begin
                    w_wait_d  = '0;
                    w_state_d = ((w_count > CNT_W'(1)) || w_push) ? PEND : IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
        end
    end

    assign stall_o = (r_state == FORCE);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed cases with literal expectations, then random traffic,
// all checked every cycle against a queue-based model of the arbitration rules.
module tb_wb_arbiter;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [4:0]      a_waddr_i;
    logic [XLEN-1:0] a_wdata_i;
    logic            a_wen_i;
    logic [XLEN-1:0] a_pc_i;
    logic            b_valid_i;
    logic            b_ready_o;
    logic [4:0]      b_waddr_i;
    logic [XLEN-1:0] b_wdata_i;
    logic [XLEN-1:0] b_pc_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic [4:0]      rd_i;
    logic            hazard_o;
    logic            stall_o;
    logic [4:0]      reg_waddr_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic            reg_wen_o;
    logic            commit_valid_o;
    logic [XLEN-1:0] commit_pc_o;
    logic            commit_src_o;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .a_waddr_i      (a_waddr_i),
        .a_wdata_i      (a_wdata_i),
        .a_wen_i        (a_wen_i),
        .a_pc_i         (a_pc_i),
        .b_valid_i      (b_valid_i),
        .b_ready_o      (b_ready_o),
        .b_waddr_i      (b_waddr_i),
        .b_wdata_i      (b_wdata_i),
        .b_pc_i         (b_pc_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rd_i           (rd_i),
        .hazard_o       (hazard_o),
        .stall_o        (stall_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o),
        .reg_wen_o      (reg_wen_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .commit_src_o   (commit_src_o)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] pc;
    } ent_t;

    // Model: buffered results in arrival order, consecutive denied cycles, predicted stall.
    ent_t        q[$];
    int unsigned denied  = 0;
    bit          stall_m = 1'b0;
    int          n_vec   = 0;
    int          n_err   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        q.delete();
        denied  = 0;
        stall_m = 1'b0;
    endfunction

    // Called at posedge+1 with inputs applied; compares all outputs at posedge+3.
    task automatic settle();
        logic        e_rdy, e_wen, e_cv, e_src, e_hz;
        logic [4:0]  e_wa;
        logic [63:0] e_wd, e_pc;
        #2;
        if (!rst) model_clear();
        e_rdy = rst && (q.size() < DEPTH);
        e_wen = 1'b0; e_cv = 1'b0; e_src = 1'b0; e_wa = 5'd0; e_wd = '0; e_pc = '0;
        if (a_wen_i) begin
            e_wen = (a_waddr_i != 5'd0);
            e_cv  = 1'b1;
            e_wa  = a_waddr_i;
            e_wd  = a_wdata_i;
            e_pc  = a_pc_i;
        end else if (q.size() != 0) begin
            e_wen = (q[0].waddr != 5'd0);
            e_cv  = 1'b1;
            e_src = 1'b1;
            e_wa  = q[0].waddr;
            e_wd  = q[0].wdata;
            e_pc  = q[0].pc;
        end
        e_hz = 1'b0;
        foreach (q[i]) begin
            if (q[i].waddr != 5'd0 &&
                (q[i].waddr == rs1_i || q[i].waddr == rs2_i || q[i].waddr == rd_i)) e_hz = 1'b1;
        end
        chk("b_ready",      64'(b_ready_o),      64'(e_rdy));
        chk("reg_wen",      64'(reg_wen_o),      64'(e_wen));
        chk("reg_waddr",    64'(reg_waddr_o),    64'(e_wa));
        chk("reg_wdata",    reg_wdata_o,         e_wd);
        chk("commit_valid", 64'(commit_valid_o), 64'(e_cv));
        chk("commit_pc",    commit_pc_o,         e_pc);
        chk("commit_src",   64'(commit_src_o),   64'(e_src));
        chk("hazard",       64'(hazard_o),       64'(e_hz));
        chk("stall",        64'(stall_o),        64'(stall_m));
    endtask

    // Apply the clock edge to the model, then move to posedge+1.
    task automatic adv();
        bit pop, push;
        if (rst) begin
            pop  = !a_wen_i && (q.size() != 0);
            push = b_valid_i && (q.size() < DEPTH);
            if (pop) begin
                void'(q.pop_front());
                denied  = 0;
                stall_m = 1'b0;
            end else if (q.size() != 0) begin
                denied++;
                if (denied >= MAX_WAIT) stall_m = 1'b1;
            end
            if (push) q.push_back('{b_waddr_i, b_wdata_i, b_pc_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input logic v, input logic [4:0] wa, input logic [63:0] wd);
        b_valid_i = v;
        b_waddr_i = wa;
        b_wdata_i = wd;
        b_pc_i    = 64'h8000_0000 + wd;
    endtask

    initial begin
        a_wen_i = 1'b0; a_waddr_i = '0; a_wdata_i = '0; a_pc_i = '0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
        set_b(1'b1, 5'd9, 64'h99);
        rst = 1'b0;
        #1;
        // Reset: ready forced low despite b_valid, everything quiet.
        settle();
        chk("rst_ready", 64'(b_ready_o), 64'd0);
        chk("rst_cv", 64'(commit_valid_o), 64'd0);
        chk("rst_wen", 64'(reg_wen_o), 64'd0);
        adv();
        settle();
        adv();
        rst = 1'b1;
        set_b(1'b0, 5'd0, 64'h0);
        settle();
        chk("rel_ready", 64'(b_ready_o), 64'd1);
        chk("rel_stall", 64'(stall_o), 64'd0);
        adv();

        // B-only write appears the cycle after acceptance.
        b_valid_i = 1'b1; b_waddr_i = 5'd5; b_wdata_i = 64'hDEAD; b_pc_i = 64'h8000_0010;
        settle();
        chk("b_nobypass", 64'(commit_valid_o), 64'd0);
        adv();
        b_valid_i = 1'b0;
        settle();
        chk("b_wen", 64'(reg_wen_o), 64'd1);
        chk("b_waddr", 64'(reg_waddr_o), 64'd5);
        chk("b_wdata", reg_wdata_o, 64'hDEAD);
        chk("b_pc", commit_pc_o, 64'h8000_0010);
        chk("b_src", 64'(commit_src_o), 64'd1);
        adv();
        settle();
        chk("b_drained", 64'(commit_valid_o), 64'd0);
        adv();

        // A priority while B fills, then starvation stall.
        a_wen_i = 1'b1; a_waddr_i = 5'd3; a_wdata_i = 64'hA3; a_pc_i = 64'h100;
        set_b(1'b1, 5'd10, 64'd1);
        settle();
        chk("a_waddr", 64'(reg_waddr_o), 64'd3);
        chk("a_src", 64'(commit_src_o), 64'd0);
        adv();
        set_b(1'b1, 5'd11, 64'd2);
        settle();
        chk("a_ready1", 64'(b_ready_o), 64'd1);
        adv();
        set_b(1'b1, 5'd12, 64'd3);
        settle();
        chk("a_full_ready", 64'(b_ready_o), 64'd0);
        adv();
        set_b(1'b0, 5'd0, 64'd0);
        for (int k = 3; k <= int'(MAX_WAIT) + 1; k++) begin
            settle();
            chk("stall_timing", 64'(stall_o), (k >= int'(MAX_WAIT) + 1) ? 64'd1 : 64'd0);
            adv();
        end
        a_wen_i = 1'b0;
        settle();
        chk("starve_pop_src", 64'(commit_src_o), 64'd1);
        chk("starve_pop_data", reg_wdata_o, 64'd1);
        chk("starve_still_stall", 64'(stall_o), 64'd1);
        adv();
        settle();
        chk("stall_cleared", 64'(stall_o), 64'd0);
        chk("second_pop", reg_wdata_o, 64'd2);
        adv();

        // x0 handling on both ports.
        a_wen_i = 1'b1; a_waddr_i = 5'd0;
        set_b(1'b1, 5'd0, 64'h77);
        settle();
        adv();
        set_b(1'b0, 5'd0, 64'd0);
        settle();
        chk("a_x0_wen", 64'(reg_wen_o), 64'd0);
        chk("a_x0_cv", 64'(commit_valid_o), 64'd1);
        chk("a_x0_src", 64'(commit_src_o), 64'd0);
        adv();
        a_wen_i = 1'b0;
        settle();
        chk("b_x0_wen", 64'(reg_wen_o), 64'd0);
        chk("b_x0_cv", 64'(commit_valid_o), 64'd1);
        chk("b_x0_data", reg_wdata_o, 64'h77);
        adv();

        // Hazard queries against buffered rd=7 and rd=0.
        a_wen_i = 1'b1; a_waddr_i = 5'd3;
        set_b(1'b1, 5'd7, 64'h70);
        settle();
        adv();
        set_b(1'b1, 5'd0, 64'h71);
        rs1_i = 5'd1; rs2_i = 5'd7; rd_i = 5'd2;
        settle();
        chk("hz_rs2", 64'(hazard_o), 64'd1);
        adv();
        set_b(1'b0, 5'd0, 64'd0);
        rs2_i = 5'd4;
        settle();
        chk("hz_none", 64'(hazard_o), 64'd0);
        adv();
        rs1_i = 5'd0; rs2_i = 5'd0; rd_i = 5'd0;
        settle();
        chk("hz_x0", 64'(hazard_o), 64'd0);
        adv();
        rd_i = 5'd7; a_wen_i = 1'b0;
        settle();
        chk("hz_rd_popping", 64'(hazard_o), 64'd1);
        adv();
        rd_i = 5'd0;
        settle();
        adv();

        // Push and pop together at count DEPTH-1 keeps order.
        set_b(1'b1, 5'd1, 64'd1);
        settle();
        adv();
        set_b(1'b1, 5'd2, 64'd2);
        settle();
        chk("sim_pop1", reg_wdata_o, 64'd1);
        chk("sim_ready", 64'(b_ready_o), 64'd1);
        adv();
        set_b(1'b1, 5'd3, 64'd3);
        settle();
        chk("sim_pop2", reg_wdata_o, 64'd2);
        adv();
        set_b(1'b0, 5'd0, 64'd0);
        settle();
        chk("sim_pop3", reg_wdata_o, 64'd3);
        adv();

        // Full with a pop in the same cycle still refuses a push.
        a_wen_i = 1'b1;
        set_b(1'b1, 5'd20, 64'd20);
        settle(); adv();
        set_b(1'b1, 5'd21, 64'd21);
        settle(); adv();
        a_wen_i = 1'b0;
        set_b(1'b1, 5'd22, 64'd22);
        settle();
        chk("full_pop_ready", 64'(b_ready_o), 64'd0);
        adv();
        set_b(1'b0, 5'd0, 64'd0);
        settle(); adv();
        settle(); adv();

        // Asynchronous reset while stalled.
        a_wen_i = 1'b1; a_waddr_i = 5'd4;
        set_b(1'b1, 5'd9, 64'h9);
        settle(); adv();
        set_b(1'b0, 5'd0, 64'd0);
        for (int k = 0; k < int'(MAX_WAIT) + 1; k++) begin
            settle(); adv();
        end
        settle();
        chk("pre_rst_stall", 64'(stall_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_stall", 64'(stall_o), 64'd0);
        chk("async_rst_ready", 64'(b_ready_o), 64'd0);
        a_wen_i = 1'b0;
        #1;
        chk("async_rst_empty", 64'(commit_valid_o), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        settle(); adv();
        rst = 1'b1;
        settle();
        chk("post_rst_empty", 64'(commit_valid_o), 64'd0);
        adv();

        // Random traffic with bursty A activity to provoke stalls.
        begin
            int unsigned a_pct;
            a_pct = 50;
            for (int n = 0; n < 3000; n++) begin
                if (n % 64 == 0) a_pct = ($urandom_range(0, 1) == 0) ? 30 : 95;
                rst       = ($urandom_range(0, 499) != 0);
                a_wen_i   = ($urandom_range(0, 99) < a_pct);
                a_waddr_i = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                a_wdata_i = {$urandom, $urandom};
                a_pc_i    = {32'd0, $urandom};
                b_valid_i = ($urandom_range(0, 1) == 1);
                b_waddr_i = 5'($urandom_range(0, 7));
                b_wdata_i = {$urandom, $urandom};
                b_pc_i    = {32'd0, $urandom};
                rs1_i     = 5'($urandom_range(0, 7));
                rs2_i     = 5'($urandom_range(0, 7));
                rd_i      = 5'($urandom_range(0, 7));
                settle();
                adv();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
